// File: rtl/candy_avb_pio_bidir_n.sv
`default_nettype none
// ============================================================================
//  Module   : candy_avb_pio_bidir_n
//  Purpose  : Avalon-MM bidirectional GPIO, WIDTH pins. Per-bit direction,
//             atomic set/clear, synchronised input sampling, sticky edge
//             capture with write-one-to-clear, masked level interrupt.
//  Ports    : clk        - bus clock
//             reset      - asynchronous active-high reset
//             address    - word address (0 DATA,1 DIR,2 MASK,3 EDGE,4 SET,5 CLR)
//             chipselect - slave select
//             write_n    - active-low write strobe
//             writedata  - write data, bits >= WIDTH ignored
//             readdata   - registered read data, bits >= WIDTH read 0
//             bidir_port - pins, bit i driven when direction bit is 1
//             irq        - registered |(edge_cap & irq_mask)
//  Revision : 1.0  initial release
// ============================================================================
module candy_avb_pio_bidir_n #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    inout  wire  [WIDTH-1:0] bidir_port,
    output logic             irq
);

    localparam logic [2:0] c_ADDR_DATA = 3'd0;
    localparam logic [2:0] c_ADDR_DIR  = 3'd1;
    localparam logic [2:0] c_ADDR_MASK = 3'd2;
    localparam logic [2:0] c_ADDR_EDGE = 3'd3;
    localparam logic [2:0] c_ADDR_SET  = 3'd4;
    localparam logic [2:0] c_ADDR_CLR  = 3'd5;

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_data_dir;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [31:0]      r_readdata;
    logic             r_irq;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_sync_in;
    logic [WIDTH-1:0] w_edge_det;
    logic [WIDTH-1:0] w_w1c;
    logic [31:0]      w_rd;

    assign w_wr      = chipselect & ~write_n;
    assign w_wd      = writedata[WIDTH-1:0];
    assign w_sync_in = r_sync[SYNC_STAGES-1];
    assign w_w1c     = (w_wr && address == c_ADDR_EDGE) ? w_wd : '0;

    // Upper write-data bits have no register behind them.
    generate
        if (WIDTH < 32) begin : g_unused_wd
            logic w_unused_wd;
            assign w_unused_wd = ^writedata[31:WIDTH];
        end
    endgenerate

    // Edge polarity is fixed at elaboration.
    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign w_edge_det = w_sync_in & ~r_prev;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge_det = ~w_sync_in & r_prev;
        end else begin : g_edge_any
            assign w_edge_det = w_sync_in ^ r_prev;
        end
    endgenerate

    // Per-pin tristate: only bits configured as outputs are driven.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_pin
            assign bidir_port[i] = r_data_dir[i] ? r_data_out[i] : 1'bz;
        end
    endgenerate

    always_comb begin
        w_rd = '0;
        case (address)
            c_ADDR_DATA: w_rd[WIDTH-1:0] = w_sync_in;
            c_ADDR_DIR:  w_rd[WIDTH-1:0] = r_data_dir;
            c_ADDR_MASK: w_rd[WIDTH-1:0] = r_irq_mask;
            c_ADDR_EDGE: w_rd[WIDTH-1:0] = r_edge_cap;
            default:     w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out <= RESET_OUT;
            r_data_dir <= RESET_DIR;
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_prev     <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= bidir_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync_in;

            // A fresh edge overrides a simultaneous clear of the same bit.
            r_edge_cap <= (r_edge_cap & ~w_w1c) | w_edge_det;

            r_irq      <= |(r_edge_cap & r_irq_mask);
            r_readdata <= w_rd;

            if (w_wr) begin
                case (address)
                    c_ADDR_DATA: r_data_out <= w_wd;
                    c_ADDR_DIR:  r_data_dir <= w_wd;
                    c_ADDR_MASK: r_irq_mask <= w_wd;
                    c_ADDR_SET:  r_data_out <= r_data_out | w_wd;
                    c_ADDR_CLR:  r_data_out <= r_data_out & ~w_wd;
                    default:     ;
                endcase
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_candy_avb_pio_bidir_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_candy_avb_pio_bidir_n
//  Purpose  : Self-checking bench for candy_avb_pio_bidir_n. A behavioural
//             model tracks register contents and a history of pin samples;
//             sync_in is simply the pin value sampled SYNC_STAGES-1 edges ago.
//  Revision : 1.0  initial release
// ============================================================================
module tb_candy_avb_pio_bidir_n;

    localparam int         W  = 8;
    localparam int         S  = 2;
    localparam int         ET = 0;
    localparam logic [7:0] RO = 8'hA5;
    localparam logic [7:0] RD = 8'h0F;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [2:0]  address    = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'h0;
    wire  [31:0] readdata;
    wire         irq;
    wire  [7:0]  bidir_port;
    logic [7:0]  tb_drv     = 8'h00;

    // Model state
    logic [7:0]  m_dout = RO;
    logic [7:0]  m_dir  = RD;
    logic [7:0]  m_mask = 8'h00;
    logic [7:0]  m_cap  = 8'h00;
    logic [31:0] m_rd   = 32'h0;
    logic        m_irq  = 1'b0;
    logic [7:0]  hist[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // The bench drives exactly the pins the model says are inputs.
    generate
        for (genvar i = 0; i < W; i++) begin : g_tb_drv
            assign bidir_port[i] = m_dir[i] ? 1'bz : tb_drv[i];
        end
    endgenerate

    candy_avb_pio_bidir_n #(
        .WIDTH      (W),
        .RESET_OUT  (RO),
        .RESET_DIR  (RD),
        .EDGE_TYPE  (ET),
        .SYNC_STAGES(S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .bidir_port(bidir_port),
        .irq       (irq)
    );

    function automatic logic [7:0] exp_pins();
        return (m_dout & m_dir) | (tb_drv & ~m_dir);
    endfunction

    task automatic model_reset();
        m_dout = RO;
        m_dir  = RD;
        m_mask = 8'h00;
        m_cap  = 8'h00;
        m_rd   = 32'h0;
        m_irq  = 1'b0;
        hist.delete();
        for (int i = 0; i < S + 1; i++) hist.push_back(8'h00);
    endtask

    // Advance one clock; model computes the post-edge state from pre-edge values.
    task automatic tick();
        logic [7:0]  s_cur, p_cur, det, w1c, pin, wd, nd, ndir, nmask, ncap;
        logic [31:0] nrd;
        logic        nirq, wr;
        int          n;
        n     = hist.size();
        s_cur = hist[n-S];
        p_cur = hist[n-S-1];
        case (ET)
            0:       det = s_cur & ~p_cur;
            1:       det = ~s_cur & p_cur;
            default: det = s_cur ^ p_cur;
        endcase
        wr    = chipselect && !write_n;
        wd    = writedata[7:0];
        w1c   = (wr && address == 3'd3) ? wd : 8'h00;
        ncap  = (m_cap & ~w1c) | det;
        nirq  = |(m_cap & m_mask);
        case (address)
            3'd0:    nrd = {24'h0, s_cur};
            3'd1:    nrd = {24'h0, m_dir};
            3'd2:    nrd = {24'h0, m_mask};
            3'd3:    nrd = {24'h0, m_cap};
            default: nrd = 32'h0;
        endcase
        nd = m_dout; ndir = m_dir; nmask = m_mask;
        if (wr) begin
            case (address)
                3'd0: nd    = wd;
                3'd1: ndir  = wd;
                3'd2: nmask = wd;
                3'd4: nd    = m_dout | wd;
                3'd5: nd    = m_dout & ~wd;
                default: ;
            endcase
        end
        pin = exp_pins();
        @(posedge clk);
        hist.push_back(pin);
        if (hist.size() > 32) void'(hist.pop_front());
        m_dout = nd; m_dir = ndir; m_mask = nmask; m_cap = ncap;
        m_rd = nrd; m_irq = nirq;
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        tb_drv = 8'h50;
        model_reset();
        @(negedge clk);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_readdata: got %h want %h", readdata, 32'h0); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_vec++; if (bidir_port[3:0] !== 4'h5) begin n_err++; $display("FAIL reset_pins_lo: got %h want 5", bidir_port[3:0]); end
        n_vec++; if (bidir_port[7:4] !== 4'h5) begin n_err++; $display("FAIL reset_pins_hi_undriven: got %h want 5 (bench value)", bidir_port[7:4]); end
        reset = 1'b0;
        idle(S + 2);
        n_vec++; if (readdata !== m_rd) begin n_err++; $display("FAIL reset_settle_rd: got %h want %h", readdata, m_rd); end
    endtask

    task automatic test_write_set_clr();
        bus_write(3'd1, 32'hFF);
        bus_write(3'd0, 32'h3C);
        bus_write(3'd4, 32'h01);
        bus_write(3'd5, 32'h0C);
        n_vec++; if (bidir_port !== 8'h31) begin n_err++; $display("FAIL setclr_pins: got %h want 31", bidir_port); end
        address = 3'd0;
        idle(S + 1);
        n_vec++; if (readdata !== 32'h31) begin n_err++; $display("FAIL setclr_read: got %h want 31", readdata); end
        address = 3'd1;
        idle(1);
        n_vec++; if (readdata !== 32'hFF) begin n_err++; $display("FAIL dir_read: got %h want ff", readdata); end
    endtask

    task automatic test_edge();
        idle(4);
        bus_write(3'd3, 32'hFF);
        tb_drv = 8'h00;
        bus_write(3'd1, 32'h00);
        idle(4);
        bus_write(3'd3, 32'hFF);
        address = 3'd3;
        idle(4);
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL edge_clear: got %h want 0", readdata); end
        tb_drv = 8'h04;
        for (int i = 0; i < S + 2; i++) begin
            tick();
            n_vec++; if (readdata !== m_rd) begin n_err++; $display("FAIL edge_latency cyc%0d: got %h want %h", i, readdata, m_rd); end
        end
        n_vec++; if (readdata !== 32'h04) begin n_err++; $display("FAIL edge_rise: got %h want 04", readdata); end
        tb_drv = 8'h00;
        idle(S + 3);
        n_vec++; if (readdata !== 32'h04) begin n_err++; $display("FAIL edge_fall_ignored: got %h want 04", readdata); end
    endtask

    task automatic test_irq();
        bus_write(3'd2, 32'h04);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_latency: got %b want 0", irq); end
        idle(1);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_assert: got %b want 1", irq); end
        bus_write(3'd3, 32'h04);
        idle(1);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_w1c: got %b want 0", irq); end
    endtask

    task automatic test_w1c_collision();
        tb_drv = 8'h04;
        idle(S + 3);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL coll_pre_irq: got %b want 1", irq); end
        tb_drv = 8'h00;
        idle(S + 3);
        tb_drv = 8'h04;
        tick();
        idle(S - 1);
        bus_write(3'd3, 32'h04);
        address = 3'd3;
        idle(1);
        n_vec++; if (readdata[2] !== 1'b1) begin n_err++; $display("FAIL coll_cap: got %b want 1", readdata[2]); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL coll_irq: got %b want 1", irq); end
        n_vec++; if (readdata !== m_rd) begin n_err++; $display("FAIL coll_model: got %h want %h", readdata, m_rd); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom);
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) tb_drv = 8'($urandom);
            tick();
            n_vec++; if (readdata !== m_rd) begin n_err++; $display("FAIL rand_rd i=%0d: got %h want %h", i, readdata, m_rd); end
            n_vec++; if (irq !== m_irq) begin n_err++; $display("FAIL rand_irq i=%0d: got %b want %b", i, irq, m_irq); end
            n_vec++; if (bidir_port !== exp_pins()) begin n_err++; $display("FAIL rand_pins i=%0d: got %h want %h", i, bidir_port, exp_pins()); end
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_async_reset();
        bus_write(3'd1, 32'h0F);
        bus_write(3'd0, 32'h0A);
        bus_write(3'd2, 32'hFF);
        bus_write(3'd3, 32'hFF);
        tb_drv = 8'h00;
        idle(S + 3);
        tb_drv = 8'h30;
        idle(S + 3);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL areset_pre_irq: got %b want 1", irq); end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL areset_irq: got %b want 0", irq); end
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL areset_rd: got %h want 0", readdata); end
        n_vec++; if (bidir_port[3:0] !== 4'h5) begin n_err++; $display("FAIL areset_pins: got %h want 5", bidir_port[3:0]); end
        @(negedge clk);
        reset   = 1'b0;
        address = 3'd3;
        tick();
        n_vec++; if (readdata !== 32'h0) begin n_err++; $display("FAIL areset_cap: got %h want 0", readdata); end
        idle(S + 2);
        n_vec++; if (readdata !== m_rd) begin n_err++; $display("FAIL areset_no_retrigger: got %h want %h", readdata, m_rd); end
    endtask

    initial begin
        test_reset();
        test_write_set_clr();
        test_edge();
        test_irq();
        test_w1c_collision();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
